// File: rtl/wb_itr_chk.sv
// Wishbone initiator-side protocol checker: counts outstanding requests
// and latches sticky violation flags without driving the bus.
module wb_itr_chk #(
    parameter int ADR_WIDTH = 16,
    parameter int SEL_WIDTH = 2,
    parameter int MAX_OUT   = 4,
    parameter int CNT_WIDTH = $clog2(MAX_OUT + 1),
    parameter int TIMEOUT   = 256,
    parameter int TO_WIDTH  = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 sync_rst_i,
    input  logic                 itr_cyc_i,
    input  logic                 itr_stb_i,
    input  logic                 itr_we_i,
    input  logic [SEL_WIDTH-1:0] itr_sel_i,
    input  logic [ADR_WIDTH-1:0] itr_adr_i,
    input  logic                 itr_ack_i,
    input  logic                 itr_err_i,
    input  logic                 itr_rty_i,
    input  logic                 itr_stall_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] outstanding_o,
    output logic                 busy_o,
    output logic [5:0]           viol_o,
    output logic [2:0]           viol_first_o,
    output logic                 viol_irq_o
);

    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TO_WIDTH-1:0]  tmr_q, tmr_d;
    logic [5:0]           viol_q, viol_d;
    logic [2:0]           first_q, first_d;
    logic                 irq_q, irq_d;

    logic       req, term, mon, abort, multi, tmr_inc;
    logic [5:0] det, viol_base;
    logic [2:0] first_base;

    // Payload signals are irrelevant to protocol checking.
    logic unused_payload;
    assign unused_payload = ^{itr_we_i, itr_sel_i, itr_adr_i};

    always_comb begin
        req     = itr_cyc_i & itr_stb_i & ~itr_stall_i;
        term    = itr_ack_i | itr_err_i | itr_rty_i;
        mon     = (state_q != S_RESET);
        abort   = (state_q == S_ACTIVE) && !itr_cyc_i && (cnt_q != '0);
        multi   = (itr_ack_i & itr_err_i) | (itr_ack_i & itr_rty_i)
                | (itr_err_i & itr_rty_i);
        tmr_inc = mon && !abort && (cnt_q != '0) && !term
                && (tmr_q != TO_WIDTH'(TIMEOUT));

        det = '0;
        if (mon) begin
            det[0] = multi;
            det[1] = term && (cnt_q == '0);
            det[2] = req && !term && (cnt_q == CNT_WIDTH'(MAX_OUT));
            det[3] = tmr_inc && (tmr_q == TO_WIDTH'(TIMEOUT - 1));
            det[4] = abort;
            det[5] = itr_stb_i && !itr_cyc_i;
        end

        state_d = state_q;
        unique case (state_q)
            S_RESET:  state_d = S_IDLE;
            S_IDLE:   if (itr_cyc_i) state_d = S_ACTIVE;
            S_ACTIVE: if (!itr_cyc_i) state_d = S_IDLE;
            default:  state_d = S_RESET;
        endcase

        cnt_d = cnt_q;
        if (mon) begin
            if (abort)
                cnt_d = '0;
            else if (req && !term && cnt_q != CNT_WIDTH'(MAX_OUT))
                cnt_d = cnt_q + 1'b1;
            else if (term && !req && cnt_q != '0)
                cnt_d = cnt_q - 1'b1;
        end

        tmr_d = tmr_q;
        if (!mon || abort || term || cnt_q == '0)
            tmr_d = '0;
        else if (tmr_inc)
            tmr_d = tmr_q + 1'b1;

        // A violation seen alongside clr_i survives the clear.
        viol_base  = clr_i ? 6'b0 : viol_q;
        first_base = clr_i ? 3'b0 : first_q;
        viol_d     = viol_base | det;
        irq_d      = |(det & ~viol_base);
        first_d    = first_base;
        if (first_base == 3'b0) begin
            for (int i = 5; i >= 0; i--) begin
                if (det[i]) first_d = 3'(i + 1);
            end
        end

        if (sync_rst_i) begin
            state_d = S_RESET;
            cnt_d   = '0;
            tmr_d   = '0;
            viol_d  = '0;
            first_d = '0;
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            tmr_q   <= '0;
            viol_q  <= '0;
            first_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            viol_q  <= viol_d;
            first_q <= first_d;
            irq_q   <= irq_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign busy_o        = (cnt_q != '0);
    assign viol_o        = viol_q;
    assign viol_first_o  = first_q;
    assign viol_irq_o    = irq_q;

endmodule

// File: tb/tb_wb_itr_chk.sv
// Directed bench for wb_itr_chk: vector table plus timeout and reset
// sequences.
module tb_wb_itr_chk;

    logic        clk_i = 1'b0;
    logic        async_rst_i, sync_rst_i;
    logic        cyc, stb, we, ack, err, rty, stall, clr;
    logic [1:0]  sel;
    logic [15:0] adr;
    logic [2:0]  outstanding_o;
    logic        busy_o;
    logic [5:0]  viol_o;
    logic [2:0]  viol_first_o;
    logic        viol_irq_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    wb_itr_chk dut (
        .clk_i        (clk_i),
        .async_rst_i  (async_rst_i),
        .sync_rst_i   (sync_rst_i),
        .itr_cyc_i    (cyc),
        .itr_stb_i    (stb),
        .itr_we_i     (we),
        .itr_sel_i    (sel),
        .itr_adr_i    (adr),
        .itr_ack_i    (ack),
        .itr_err_i    (err),
        .itr_rty_i    (rty),
        .itr_stall_i  (stall),
        .clr_i        (clr),
        .outstanding_o(outstanding_o),
        .busy_o       (busy_o),
        .viol_o       (viol_o),
        .viol_first_o (viol_first_o),
        .viol_irq_o   (viol_irq_o)
    );

    // Input word layout: {cyc, stb, ack, err, rty, stall, clr}
    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] CYC    = 7'b1000000;
    localparam logic [6:0] REQ    = 7'b1100000;
    localparam logic [6:0] ACK    = 7'b1010000;
    localparam logic [6:0] ERR    = 7'b1001000;
    localparam logic [6:0] AE     = 7'b1011000;
    localparam logic [6:0] CLR    = 7'b0000001;
    localparam logic [6:0] CLRCYC = 7'b1000001;
    localparam logic [6:0] STB    = 7'b0100000;
    localparam logic [6:0] STALL  = 7'b1100010;
    localparam logic [6:0] REQACK = 7'b1110000;
    localparam logic [6:0] REQRTY = 7'b1100100;

    typedef struct {
        logic [6:0] in;
        logic [2:0] cnt;
        logic [5:0] viol;
        logic [2:0] first;
        logic       irq;
    } vec_t;

    localparam int NV = 34;
    vec_t tv[NV];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drv(input logic [6:0] v);
        {cyc, stb, ack, err, rty, stall, clr} = v;
    endtask

    task automatic step(input logic [6:0] v);
        drv(v);
        @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"}, 32'(outstanding_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_viol"}, 32'(viol_o), 0);
        chk({tag, "_first"}, 32'(viol_first_o), 0);
        chk({tag, "_irq"}, 32'(viol_irq_o), 0);
    endtask

    int hit;
    int irqs;

    initial begin
        tv[0]  = '{REQ,    3'd1, 6'b000000, 3'd0, 1'b0};
        tv[1]  = '{REQ,    3'd2, 6'b000000, 3'd0, 1'b0};
        tv[2]  = '{REQ,    3'd3, 6'b000000, 3'd0, 1'b0};
        tv[3]  = '{REQ,    3'd4, 6'b000000, 3'd0, 1'b0};
        tv[4]  = '{ACK,    3'd3, 6'b000000, 3'd0, 1'b0};
        tv[5]  = '{ACK,    3'd2, 6'b000000, 3'd0, 1'b0};
        tv[6]  = '{ACK,    3'd1, 6'b000000, 3'd0, 1'b0};
        tv[7]  = '{ACK,    3'd0, 6'b000000, 3'd0, 1'b0};
        tv[8]  = '{CYC,    3'd0, 6'b000000, 3'd0, 1'b0};
        tv[9]  = '{REQ,    3'd1, 6'b000000, 3'd0, 1'b0};
        tv[10] = '{REQ,    3'd2, 6'b000000, 3'd0, 1'b0};
        tv[11] = '{REQ,    3'd3, 6'b000000, 3'd0, 1'b0};
        tv[12] = '{REQ,    3'd4, 6'b000000, 3'd0, 1'b0};
        tv[13] = '{REQ,    3'd4, 6'b000100, 3'd3, 1'b1};
        tv[14] = '{CYC,    3'd4, 6'b000100, 3'd3, 1'b0};
        tv[15] = '{CLRCYC, 3'd4, 6'b000000, 3'd0, 1'b0};
        tv[16] = '{ACK,    3'd3, 6'b000000, 3'd0, 1'b0};
        tv[17] = '{ACK,    3'd2, 6'b000000, 3'd0, 1'b0};
        tv[18] = '{ACK,    3'd1, 6'b000000, 3'd0, 1'b0};
        tv[19] = '{ACK,    3'd0, 6'b000000, 3'd0, 1'b0};
        tv[20] = '{NONE,   3'd0, 6'b000000, 3'd0, 1'b0};
        tv[21] = '{AE,     3'd0, 6'b000011, 3'd1, 1'b1};
        tv[22] = '{CLR,    3'd0, 6'b000000, 3'd0, 1'b0};
        tv[23] = '{STB,    3'd0, 6'b100000, 3'd6, 1'b1};
        tv[24] = '{REQ,    3'd1, 6'b100000, 3'd6, 1'b0};
        tv[25] = '{REQ,    3'd2, 6'b100000, 3'd6, 1'b0};
        tv[26] = '{CLR,    3'd0, 6'b010000, 3'd5, 1'b1};
        tv[27] = '{NONE,   3'd0, 6'b010000, 3'd5, 1'b0};
        tv[28] = '{STALL,  3'd0, 6'b010000, 3'd5, 1'b0};
        tv[29] = '{REQACK, 3'd0, 6'b010010, 3'd5, 1'b1};
        tv[30] = '{REQ,    3'd1, 6'b010010, 3'd5, 1'b0};
        tv[31] = '{REQRTY, 3'd1, 6'b010010, 3'd5, 1'b0};
        tv[32] = '{ERR,    3'd0, 6'b010010, 3'd5, 1'b0};
        tv[33] = '{NONE,   3'd0, 6'b010010, 3'd5, 1'b0};

        we = 1'b0;
        sel = 2'b11;
        adr = 16'h1234;
        sync_rst_i = 1'b0;
        async_rst_i = 1'b1;
        drv(NONE);
        #12;
        chk_all_zero("rst");
        @(negedge clk_i);
        async_rst_i = 1'b0;
        step(NONE);

        for (int i = 0; i < NV; i++) begin
            drv(tv[i].in);
            @(negedge clk_i);
            chk($sformatf("v%0d_cnt", i), 32'(outstanding_o), 32'(tv[i].cnt));
            chk($sformatf("v%0d_busy", i), 32'(busy_o),
                32'(tv[i].cnt != 3'd0));
            chk($sformatf("v%0d_viol", i), 32'(viol_o), 32'(tv[i].viol));
            chk($sformatf("v%0d_first", i), 32'(viol_first_o),
                32'(tv[i].first));
            chk($sformatf("v%0d_irq", i), 32'(viol_irq_o), 32'(tv[i].irq));
        end

        // Timeout: one req, then silence until the flag appears.
        step(CLR);
        chk("to_pre_viol", 32'(viol_o), 0);
        step(REQ);
        chk("to_pre_cnt", 32'(outstanding_o), 1);
        hit = 0;
        irqs = 0;
        for (int j = 1; j <= 262; j++) begin
            step(CYC);
            if (viol_irq_o === 1'b1) irqs++;
            if (hit == 0 && viol_o[3] === 1'b1) hit = j;
        end
        chk("to_cycle", 32'(hit), 256);
        chk("to_irqs", 32'(irqs), 1);
        chk("to_first", 32'(viol_first_o), 4);
        chk("to_viol", 32'(viol_o), 32'(6'b001000));
        step(ACK);
        chk("to_ack_cnt", 32'(outstanding_o), 0);
        chk("to_ack_irq", 32'(viol_irq_o), 0);
        step(CYC);
        chk("to_after_irq", 32'(viol_irq_o), 0);
        chk("to_after_viol", 32'(viol_o), 32'(6'b001000));

        // Asynchronous reset mid-transaction.
        step(REQ);
        step(REQ);
        step(REQ);
        chk("ar_pre_cnt", 32'(outstanding_o), 3);
        drv(CYC);
        #2 async_rst_i = 1'b1;
        #1 chk_all_zero("ar_now");
        drv(STB);
        #1 async_rst_i = 1'b0;
        @(negedge clk_i);
        chk_all_zero("ar_rstate");
        step(NONE);
        chk_all_zero("ar_idle");
        step(STB);
        chk("ar_mon_viol", 32'(viol_o), 32'(6'b100000));
        chk("ar_mon_first", 32'(viol_first_o), 6);

        // Synchronous reset mid-transaction.
        step(CLR);
        step(REQ);
        step(REQ);
        chk("sr_pre_cnt", 32'(outstanding_o), 2);
        sync_rst_i = 1'b1;
        step(STB);
        sync_rst_i = 1'b0;
        chk_all_zero("sr_now");
        step(STB);
        chk_all_zero("sr_rstate");
        step(NONE);
        chk_all_zero("sr_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
